alu_seq_ctrl: RTL

Sequencer for the 6502 ALU. It accepts one ALU command per valid/ready handshake and drives the ALU's one-hot operation strobes, carry-in and result output enables on the correct cycles. It captures the ALU flag outputs into a processor-status flag register and signals completion. It sits between instruction decode and the `alu` instance; nothing else drives the ALU control pins.

---
 rtl/alu_seq_pkg.sv | 48 ++++
 rtl/alu_op_decode.sv | 74 +++++++
 rtl/alu_seq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the 6502 ALU sequencer slice. This package holds
// the opcode codes, the sequencer state enum, the flag register bit
// positions, the strobe vector bit positions and the per-opcode flag masks.
// A flag mask marks which flag bits the ALU result overwrites.
// The package is imported by alu_op_decode and alu_seq_ctrl.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_EOR = 4'd3;
  localparam logic [3:0] OP_ORA = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DRIVE = 2'd3
  } state_e;

  // Flag register layout {D,N,V,Z,C}
  localparam int FLAG_D = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;
  localparam int NUM_FLAGS = 5;

  // One bit per ALU operation strobe
  localparam int STB_SUMS   = 0;
  localparam int STB_SUBS   = 1;
  localparam int STB_ANDS   = 2;
  localparam int STB_EORS   = 3;
  localparam int STB_ORS    = 4;
  localparam int STB_SHFTR  = 5;
  localparam int STB_SHFTCR = 6;
  localparam int NUM_STB    = 7;

  // D is never part of any mask, so the ALU can never touch decimal mode
  localparam logic [NUM_FLAGS-1:0] MASK_ARITH = 5'b01111;
  localparam logic [NUM_FLAGS-1:0] MASK_LOGIC = 5'b01010;
  localparam logic [NUM_FLAGS-1:0] MASK_SHIFT = 5'b01011;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Purely combinational opcode decoder for the ALU sequencer.
// Ports:
//   op_i      opcode (0..7 legal, 8..15 illegal)
//   carry_i   current carry flag, forwarded as carry-in where the op uses it
//   strobe_o  one-hot ALU operation strobe vector (zero for illegal codes)
//   cin_o     ALU carry-in for this opcode
//   mask_o    flag bits the ALU result will overwrite, {D,N,V,Z,C}
//   cmp_o     high for CMP, which must never drive a result bus
//   illegal_o high for opcodes 8..15
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0]           op_i,
  input  logic                 carry_i,
  output logic [NUM_STB-1:0]   strobe_o,
  output logic                 cin_o,
  output logic [NUM_FLAGS-1:0] mask_o,
  output logic                 cmp_o,
  output logic                 illegal_o
);

  // Map each opcode onto its strobe, carry-in source and flag mask.
  // CMP reuses the subtractor with a forced carry-in of 1 so the
  // comparison is a borrow-free subtraction.
  always_comb begin
    strobe_o  = '0;
    cin_o     = 1'b0;
    mask_o    = '0;
    cmp_o     = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADC: begin
        strobe_o[STB_SUMS] = 1'b1;
        cin_o              = carry_i;
        mask_o             = MASK_ARITH;
      end
      OP_SBC: begin
        strobe_o[STB_SUBS] = 1'b1;
        cin_o              = carry_i;
        mask_o             = MASK_ARITH;
      end
      OP_AND: begin
        strobe_o[STB_ANDS] = 1'b1;
        mask_o             = MASK_LOGIC;
      end
      OP_EOR: begin
        strobe_o[STB_EORS] = 1'b1;
        mask_o             = MASK_LOGIC;
      end
      OP_ORA: begin
        strobe_o[STB_ORS] = 1'b1;
        mask_o            = MASK_LOGIC;
      end
      OP_LSR: begin
        strobe_o[STB_SHFTR] = 1'b1;
        mask_o              = MASK_SHIFT;
      end
      OP_ROR: begin
        strobe_o[STB_SHFTCR] = 1'b1;
        cin_o                = carry_i;
        mask_o               = MASK_SHIFT;
      end
      OP_CMP: begin
        strobe_o[STB_SUBS] = 1'b1;
        cin_o              = 1'b1;
        mask_o             = MASK_SHIFT;
        cmp_o              = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Sequencer between instruction decode and the 6502 ALU. It accepts one
// command per valid/ready handshake, pulses one ALU strobe for a cycle,
// then asserts the result output enables and captures the ALU flags into
// the {D,N,V,Z,C} status register.
// Ports:
//   clk, reset                clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op, cmd_dst           opcode and result destination {SB,ADL}
//   done, err                 completion pulse, illegal-opcode pulse
//   flag_wr, flag_in, flags   direct flag write and the flag register
//   alu_cout/zero/ovf/neg     ALU flag outputs
//   alu_*                     ALU control pins (strobes, carry-in, enables,
//                             decimal enable, ALU reset)
// Parameter RST_HOLD (1..15): cycles alu_rst stays high after reset release.
// Build option: define ALU_SEQ_DECIMAL_EN to drive alu_decen from the D flag
// during ADC/SBC; without it alu_decen is tied low and D is only storable.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_dst,
  output logic       done,
  output logic       err,
  input  logic       flag_wr,
  input  logic [4:0] flag_in,
  output logic [4:0] flags,
  input  logic       alu_cout,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  input  logic       alu_neg,
  output logic       alu_cin,
  output logic       alu_sums,
  output logic       alu_subs,
  output logic       alu_ands,
  output logic       alu_eors,
  output logic       alu_ors,
  output logic       alu_shftr,
  output logic       alu_shftcr,
  output logic       alu_decen,
  output logic       alu_rst,
  output logic       alu_adloa,
  output logic       alu_sboa
);

  localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

  state_e                 state_q;
  logic [3:0]             hold_cnt_q;
  logic [NUM_STB-1:0]     stb_q;
  logic                   cin_q;
  logic                   decen_q;
  logic                   rst_q;
  logic                   ready_q;
  logic                   done_q;
  logic                   err_q;
  logic                   adloa_q;
  logic                   sboa_q;
  logic [1:0]             dst_q;
  logic                   cmp_q;
  logic [NUM_FLAGS-1:0]   mask_q;
  logic [NUM_FLAGS-1:0]   flags_q;
  logic [NUM_FLAGS-1:0]   flags_d;
  logic [NUM_FLAGS-1:0]   alu_vec;
  logic                   accept;

  logic [NUM_STB-1:0]     dec_stb;
  logic                   dec_cin;
  logic [NUM_FLAGS-1:0]   dec_mask;
  logic                   dec_cmp;
  logic                   dec_illegal;

  assign accept  = cmd_valid & ready_q;
  assign alu_vec = {1'b0, alu_neg, alu_ovf, alu_zero, alu_cout};

  // The decoder sees the carry the flag register will hold during EXEC,
  // so a back-to-back ADC picks up the carry captured in the same edge.
  alu_op_decode u_decode (
    .op_i      (cmd_op),
    .carry_i   (flags_d[FLAG_C]),
    .strobe_o  (dec_stb),
    .cin_o     (dec_cin),
    .mask_o    (dec_mask),
    .cmp_o     (dec_cmp),
    .illegal_o (dec_illegal)
  );

  // Next flag value. A direct write is applied first, then a DRIVE capture
  // overlays the ALU outputs on the masked bits, so the ALU wins where it
  // updates and flag_in supplies the rest. Writes are ignored during INIT.
  always_comb begin
    flags_d = flags_q;
    if (state_q != ST_INIT && flag_wr) begin
      flags_d = flag_in;
    end
    if (state_q == ST_DRIVE) begin
      flags_d = (alu_vec & mask_q) | (flags_d & ~mask_q);
    end
  end

  // Sequencer FSM. Every ALU control is a registered output, cleared by
  // default each cycle so strobes and pulses last exactly one cycle.
  // The asynchronous reset drops all strobes immediately and clears flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      hold_cnt_q <= '0;
      stb_q      <= '0;
      cin_q      <= 1'b0;
      decen_q    <= 1'b0;
      rst_q      <= 1'b1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      adloa_q    <= 1'b0;
      sboa_q     <= 1'b0;
      dst_q      <= '0;
      cmp_q      <= 1'b0;
      mask_q     <= '0;
      flags_q    <= '0;
    end else begin
      stb_q   <= '0;
      cin_q   <= 1'b0;
      decen_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      adloa_q <= 1'b0;
      sboa_q  <= 1'b0;
      flags_q <= flags_d;
      case (state_q)
        ST_INIT: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q <= ST_IDLE;
            rst_q   <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end
        ST_IDLE, ST_DRIVE: begin
          if (accept && !dec_illegal) begin
            state_q <= ST_EXEC;
            ready_q <= 1'b0;
            stb_q   <= dec_stb;
            cin_q   <= dec_cin;
            dst_q   <= cmd_dst;
            cmp_q   <= dec_cmp;
            mask_q  <= dec_mask;
`ifdef ALU_SEQ_DECIMAL_EN
            decen_q <= (dec_stb[STB_SUMS] | dec_stb[STB_SUBS]) & ~dec_cmp
                       & flags_d[FLAG_D];
`endif
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            err_q   <= accept;
          end
        end
        ST_EXEC: begin
          state_q <= ST_DRIVE;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
          adloa_q <= dst_q[0] & ~cmp_q;
          sboa_q  <= dst_q[1] & ~cmp_q;
        end
        default: begin
          state_q <= ST_INIT;
          ready_q <= 1'b0;
          rst_q   <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = ready_q;
  assign done       = done_q;
  assign err        = err_q;
  assign flags      = flags_q;
  assign alu_cin    = cin_q;
  assign alu_sums   = stb_q[STB_SUMS];
  assign alu_subs   = stb_q[STB_SUBS];
  assign alu_ands   = stb_q[STB_ANDS];
  assign alu_eors   = stb_q[STB_EORS];
  assign alu_ors    = stb_q[STB_ORS];
  assign alu_shftr  = stb_q[STB_SHFTR];
  assign alu_shftcr = stb_q[STB_SHFTCR];
  assign alu_decen  = decen_q;
  assign alu_rst    = rst_q;
  assign alu_adloa  = adloa_q;
  assign alu_sboa   = sboa_q;

endmodule
